// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator and its counter watcher.
package pwm_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_t;

  function automatic logic isGenerating(input state_t s);
    return (s == RUN) || (s == STOP);
  endfunction

endpackage

// File: rtl/cnt_watch.sv
// Watches the upstream counter: flags period boundaries and illegal count steps.
module cnt_watch
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count,
  output logic             boundary,
  output logic             seq_violation
);

  logic [CNT_W-1:0] r_prev_count;
  logic [CNT_W-1:0] w_next_expected;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_count <= '0;
    end else begin
      r_prev_count <= count;
    end
  end

  always_comb begin
    w_next_expected = (r_prev_count == CNT_MAX) ? '0 : r_prev_count + 4'd1;
  end

  // A jump to zero is always legal: it is either a wrap or an upstream reset.
  assign boundary      = (count == '0) && (r_prev_count != '0);
  assign seq_violation = (count != w_next_expected) && (count != '0);

endmodule

// File: rtl/pwm_gen.sv
// PWM generator locked to an external free-running 4-bit counter, with a
// shadowed duty register that only takes effect at period boundaries.
module pwm_gen
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count,
  input  logic             en,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic             clr_err,
  output logic             pwm_out,
  output logic             period_done,
  output logic             busy,
  output logic             seq_err
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_shadow;
  logic             r_full;
  logic [CNT_W-1:0] r_active_duty;
  logic             r_pwm_out;
  logic             r_period_done;
  logic             r_seq_err;
  logic             w_boundary;
  logic             w_seq_violation;
  logic             w_accept;
  logic             w_apply;
  logic [CNT_W-1:0] w_duty_cmp;
  logic             w_busy;

  cnt_watch u_cnt_watch (
    .clk           (clk),
    .rst           (rst),
    .count         (count),
    .boundary      (w_boundary),
    .seq_violation (w_seq_violation)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A running period is never cut short: dropping en mid-period parks in STOP.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (en) w_next_state = ARM;
      ARM: begin
        if (!en)             w_next_state = IDLE;
        else if (w_boundary) w_next_state = RUN;
      end
      RUN: begin
        if (w_boundary)      w_next_state = en ? RUN : IDLE;
        else if (!en)        w_next_state = STOP;
      end
      STOP: if (w_boundary) w_next_state = en ? RUN : IDLE;
      default:              w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  // Accept and apply are exclusive (one needs the shadow empty, the other full).
  assign w_accept   = duty_valid && !r_full;
  assign w_apply    = w_boundary && r_full && (w_next_state == RUN);
  assign w_duty_cmp = w_apply ? r_shadow : r_active_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow      <= '0;
      r_full        <= 1'b0;
      r_active_duty <= '0;
      r_pwm_out     <= 1'b0;
      r_period_done <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shadow <= duty_in;
        r_full   <= 1'b1;
      end else if (w_apply) begin
        r_full   <= 1'b0;
      end
      if (w_apply) begin
        r_active_duty <= r_shadow;
      end
      r_pwm_out     <= isGenerating(w_next_state) && (count < w_duty_cmp);
      r_period_done <= w_boundary && isGenerating(r_state);
      if (w_seq_violation) begin
        r_seq_err <= 1'b1;
      end else if (clr_err) begin
        r_seq_err <= 1'b0;
      end
    end
  end

  assign duty_ready  = !r_full;
  assign pwm_out     = r_pwm_out;
  assign period_done = r_period_done;
  assign busy        = w_busy;
  assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: the driver queues hand-derived expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pwm_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic       en;
  logic [3:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       clr_err;
  logic       pwm_out;
  logic       period_done;
  logic       busy;
  logic       seq_err;

  typedef struct {
    string name;
    int    pwm;
    int    pd;
    int    busy;
    int    err;
    int    rdy;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  pwm_gen dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .en          (en),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .clr_err     (clr_err),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .busy        (busy),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  task automatic cmpField(input string nm, input string field, input int act, input int want);
    if (want >= 0) begin
      total++;
      if (act != want) begin
        bad++;
        $display("[TB] FAIL %s.%s got=%0d want=%0d at %0t", nm, field, act, want, $time);
      end
    end
  endtask

  // Monitor: outputs are stable at the falling edge, well away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        cmpField(e.name, "pwm_out",     int'(pwm_out),     e.pwm);
        cmpField(e.name, "period_done", int'(period_done), e.pd);
        cmpField(e.name, "busy",        int'(busy),        e.busy);
        cmpField(e.name, "seq_err",     int'(seq_err),     e.err);
        cmpField(e.name, "duty_ready",  int'(duty_ready),  e.rdy);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] c);
    count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input int p, input int pd, input int b,
                             input int er, input int rdy);
    exp_t e;
    e.name = nm;
    e.pwm  = p;
    e.pd   = pd;
    e.busy = b;
    e.err  = er;
    e.rdy  = rdy;
    expQ.push_back(e);
  endtask

  // Steps the counter through from..to with no boundary; pwm high while count < duty.
  task automatic runSpan(input string nm, input int from, input int to, input int duty,
                         input int gen, input int rdy);
    for (int c = from; c <= to; c++) begin
      applyStimulus(4'(c));
      checkOutput(nm, (gen != 0 && c < duty) ? 1 : 0, 0, 1, 0, rdy);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; duty_valid = 1'b0; duty_in = 4'd0; clr_err = 1'b0; count = 4'd0;

    applyStimulus(4'd0);  checkOutput("reset", 0, 0, 0, 0, 1);
    duty_valid = 1'b1; duty_in = 4'd9;
    applyStimulus(4'd0);  checkOutput("reset_drop", 0, 0, 0, 0, 1);

    rst = 1'b0; duty_in = 4'd4;
    applyStimulus(4'd1);  checkOutput("load4", 0, 0, 0, 0, 0);
    duty_valid = 1'b0; en = 1'b1;
    applyStimulus(4'd2);  checkOutput("arm", 0, 0, 1, 0, 0);
    runSpan("arm_wait", 3, 15, 0, 0, 0);
    applyStimulus(4'd0);  checkOutput("arm_to_run", 1, 0, 1, 0, 1);
    runSpan("duty4", 1, 15, 4, 1, 1);
    applyStimulus(4'd0);  checkOutput("duty4_wrap", 1, 1, 1, 0, 1);

    runSpan("duty4", 1, 1, 4, 1, 1);
    duty_valid = 1'b1; duty_in = 4'd10;
    applyStimulus(4'd2);  checkOutput("offer10", 1, 0, 1, 0, 0);
    duty_valid = 1'b0;
    runSpan("hold4", 3, 15, 4, 1, 0);
    applyStimulus(4'd0);  checkOutput("apply10", 1, 1, 1, 0, 1);

    runSpan("duty10", 1, 1, 10, 1, 1);
    duty_valid = 1'b1; duty_in = 4'd12;
    applyStimulus(4'd2);  checkOutput("offer12", 1, 0, 1, 0, 0);
    duty_valid = 1'b0;
    runSpan("duty10", 3, 15, 10, 1, 0);
    applyStimulus(4'd0);  checkOutput("apply12", 1, 1, 1, 0, 1);
    runSpan("duty12", 1, 6, 12, 1, 1);
    en = 1'b0;
    applyStimulus(4'd7);  checkOutput("stop", 1, 0, 1, 0, 1);
    runSpan("stop_finish", 8, 15, 12, 1, 1);
    applyStimulus(4'd0);  checkOutput("stop_to_idle", 0, 1, 0, 0, 1);
    applyStimulus(4'd1);  checkOutput("idle", 0, 0, 0, 0, 1);

    en = 1'b1; duty_valid = 1'b1; duty_in = 4'd5;
    applyStimulus(4'd2);  checkOutput("rearm", 0, 0, 1, 0, 0);
    duty_valid = 1'b0;
    runSpan("arm_wait5", 3, 15, 0, 0, 0);
    applyStimulus(4'd0);  checkOutput("run5", 1, 0, 1, 0, 1);
    runSpan("duty5", 1, 9, 5, 1, 1);
    applyStimulus(4'd0);  checkOutput("upstream_reset", 1, 1, 1, 0, 1);
    runSpan("duty5_after", 1, 3, 5, 1, 1);

    applyStimulus(4'd7);  checkOutput("seq_jump", 0, 0, 1, 1, 1);
    applyStimulus(4'd8);  checkOutput("seq_hold", 0, 0, 1, 1, 1);
    clr_err = 1'b1;
    applyStimulus(4'd9);  checkOutput("seq_clr", 0, 0, 1, 0, 1);
    applyStimulus(4'd11); checkOutput("set_wins", 0, 0, 1, 1, 1);
    applyStimulus(4'd12); checkOutput("seq_clr2", 0, 0, 1, 0, 1);
    clr_err = 1'b0;
    runSpan("duty5_tail", 13, 15, 5, 1, 1);
    applyStimulus(4'd0);  checkOutput("wrap5", 1, 1, 1, 0, 1);

    runSpan("duty5", 1, 1, 5, 1, 1);
    duty_valid = 1'b1; duty_in = 4'd15;
    applyStimulus(4'd2);  checkOutput("offer15", 1, 0, 1, 0, 0);
    duty_valid = 1'b0;
    runSpan("hold5", 3, 15, 5, 1, 0);
    applyStimulus(4'd0);  checkOutput("apply15", 1, 1, 1, 0, 1);
    runSpan("duty15", 1, 15, 15, 1, 1);
    applyStimulus(4'd0);  checkOutput("wrap15", 1, 1, 1, 0, 1);
    runSpan("duty15", 1, 2, 15, 1, 1);

    duty_valid = 1'b1; duty_in = 4'd9;
    applyStimulus(4'd3);  checkOutput("offer9", 1, 0, 1, 0, 0);
    duty_in = 4'd7; rst = 1'b1;
    applyStimulus(4'd0);  checkOutput("rst_mid", 0, 0, 0, 0, 1);
    applyStimulus(4'd0);  checkOutput("rst_hold", 0, 0, 0, 0, 1);
    rst = 1'b0; duty_valid = 1'b0; en = 1'b1;
    applyStimulus(4'd1);  checkOutput("rearm2", 0, 0, 1, 0, 1);
    runSpan("arm_wait0", 2, 15, 0, 0, 1);
    applyStimulus(4'd0);  checkOutput("duty0_start", 0, 0, 1, 0, 1);
    runSpan("duty0", 1, 15, 0, 1, 1);
    applyStimulus(4'd0);  checkOutput("duty0_wrap", 0, 1, 1, 0, 1);
    en = 1'b0;
    applyStimulus(4'd1);  checkOutput("stop2", 0, 0, 1, 0, 1);

    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
